// File: rtl/pair_align.sv
// Pairs beats from two independent AXI-Stream-like image inputs (X and Y), one beat per cycle,
// and tracks frame position to flag tlast misalignment on either input.
module pair_align_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    // Storage is left unreset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

module pair_align #(
    parameter  int PIXELS_PER_BEAT = 16,
    parameter  int IMAGE_DIM       = 512,
    parameter  int FIFO_DEPTH      = 4,
    localparam int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    localparam int BEATS           = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT,
    localparam int CNT_W           = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_x_tdata,
    input  logic                  s_x_tvalid,
    output logic                  s_x_tready,
    input  logic                  s_x_tlast,
    input  logic [DATA_WIDTH-1:0] s_y_tdata,
    input  logic                  s_y_tvalid,
    output logic                  s_y_tready,
    input  logic                  s_y_tlast,
    input  logic                  m_hold,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic                  stall,
    output logic                  frame_end,
    output logic                  tlast_err
);
    // Lane 0 is X, lane 1 is Y; each word is {tlast, tdata}.
    logic [1:0][DATA_WIDTH:0] fifo_din;
    logic [1:0][DATA_WIDTH:0] fifo_dout;
    logic [1:0]               fifo_push;
    logic [1:0]               fifo_full;
    logic [1:0]               fifo_empty;
    logic                     pop;
    logic                     at_last;
    logic [CNT_W-1:0]         beat_cnt;

    // The active-high reset also drops tready so nothing is accepted while held.
    assign s_x_tready   = ~fifo_full[0] & ~aresetn;
    assign s_y_tready   = ~fifo_full[1] & ~aresetn;
    assign fifo_din[0]  = {s_x_tlast, s_x_tdata};
    assign fifo_din[1]  = {s_y_tlast, s_y_tdata};
    assign fifo_push[0] = s_x_tvalid & s_x_tready;
    assign fifo_push[1] = s_y_tvalid & s_y_tready;

    assign pop     = ~fifo_empty[0] & ~fifo_empty[1] & ~m_hold;
    assign at_last = (beat_cnt == CNT_W'(BEATS - 1));

    for (genvar i = 0; i < 2; i++) begin : g_fifo
        pair_align_fifo #(
            .W     (DATA_WIDTH + 1),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (aresetn),
            .push  (fifo_push[i]),
            .din   (fifo_din[i]),
            .pop   (pop),
            .dout  (fifo_dout[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    always_ff @(posedge clk or posedge aresetn) begin
        if (aresetn) begin
            out_x     <= '0;
            out_y     <= '0;
            stall     <= 1'b1;
            frame_end <= 1'b0;
            tlast_err <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            stall     <= ~pop;
            frame_end <= pop & at_last;
            if (pop) begin
                out_x    <= fifo_dout[0][DATA_WIDTH-1:0];
                out_y    <= fifo_dout[1][DATA_WIDTH-1:0];
                beat_cnt <= at_last ? '0 : beat_cnt + CNT_W'(1);
                // Sticky: a misplaced tlast is reported but never resynchronises the count.
                if ((fifo_dout[0][DATA_WIDTH] != at_last) || (fifo_dout[1][DATA_WIDTH] != at_last))
                    tlast_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pair_align.sv
// Scoreboard bench for pair_align: drivers queue expected beats on handshake, a negedge
// monitor pops and compares every issued pair plus the frame/tlast flags.
module tb_pair_align;
    localparam int PPB   = 16;
    localparam int DIM   = 512;
    localparam int DEPTH = 4;
    localparam int DW    = 8 * PPB;
    localparam int BEATS = DIM * DIM / PPB;

    logic          clk = 1'b0;
    logic          aresetn = 1'b1;
    logic [DW-1:0] s_x_tdata = '0, s_y_tdata = '0;
    logic          s_x_tvalid = 1'b0, s_y_tvalid = 1'b0;
    logic          s_x_tlast = 1'b0, s_y_tlast = 1'b0;
    logic          s_x_tready, s_y_tready;
    logic          m_hold = 1'b0;
    logic [DW-1:0] out_x, out_y;
    logic          stall, frame_end, tlast_err;

    always #5 clk = ~clk;

    pair_align #(
        .PIXELS_PER_BEAT (PPB),
        .IMAGE_DIM       (DIM),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .s_x_tdata  (s_x_tdata),
        .s_x_tvalid (s_x_tvalid),
        .s_x_tready (s_x_tready),
        .s_x_tlast  (s_x_tlast),
        .s_y_tdata  (s_y_tdata),
        .s_y_tvalid (s_y_tvalid),
        .s_y_tready (s_y_tready),
        .s_y_tlast  (s_y_tlast),
        .m_hold     (m_hold),
        .out_x      (out_x),
        .out_y      (out_y),
        .stall      (stall),
        .frame_end  (frame_end),
        .tlast_err  (tlast_err)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        int            idx;
    } ent_t;

    ent_t xq[$];
    ent_t yq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   fe_cnt = 0;
    bit   err_model = 1'b0;

    function automatic logic [DW-1:0] xdat(input int k);
        return {4{8'h10, 24'(k + 1)}};
    endfunction

    function automatic logic [DW-1:0] ydat(input int k);
        return {4{8'h20, 24'(k + 1)}};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Monitor: every issued pair must match the oldest queued X and Y beats.
    ent_t xe, ye;
    bit   exp_fe;
    always @(negedge clk) begin
        if (!aresetn) begin
            if (!stall) begin
                chk("pending_expected", 1'(xq.size() != 0 && yq.size() != 0), 1'b1);
                if (xq.size() != 0 && yq.size() != 0) begin
                    xe = xq.pop_front();
                    ye = yq.pop_front();
                    exp_fe = (xe.idx == BEATS - 1);
                    err_model = err_model | (xe.last != exp_fe) | (ye.last != exp_fe);
                    chk("out_x", out_x, xe.d);
                    chk("out_y", out_y, ye.d);
                    chk("frame_end", 1'(frame_end), 1'(exp_fe));
                    chk("tlast_err", 1'(tlast_err), 1'(err_model));
                    if (frame_end) fe_cnt++;
                end
            end else begin
                chk("frame_end_idle", 1'(frame_end), 1'b0);
                chk("tlast_err_idle", 1'(tlast_err), 1'(err_model));
            end
        end
    end

    task automatic send(input bit is_y, input int start, input int n, input int bad_idx);
        for (int k = 0; k < n; k++) begin
            int            idx;
            int            w;
            logic          last;
            logic [DW-1:0] d;
            idx  = (start + k) % BEATS;
            last = (idx == BEATS - 1) || (idx == bad_idx);
            d    = is_y ? ydat(start + k) : xdat(start + k);
            @(negedge clk);
            if (is_y) begin
                s_y_tdata = d; s_y_tlast = last; s_y_tvalid = 1'b1;
            end else begin
                s_x_tdata = d; s_x_tlast = last; s_x_tvalid = 1'b1;
            end
            w = 0;
            while (!(is_y ? s_y_tready : s_x_tready) && w < 1000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 1000) begin
                n_chk++;
                $display("FAIL ready_timeout: lane %0d beat %0d never accepted", is_y, k);
                if (is_y) s_y_tvalid = 1'b0; else s_x_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            if (is_y) yq.push_back('{d, last, idx});
            else      xq.push_back('{d, last, idx});
        end
        @(negedge clk);
        if (is_y) s_y_tvalid = 1'b0; else s_x_tvalid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((xq.size() != 0 || yq.size() != 0) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            n_chk++;
            $display("FAIL drain_timeout: %0d X and %0d Y beats never issued", xq.size(), yq.size());
        end
    endtask

    // Asserts reset mid-cycle and checks outputs before any clock edge can occur.
    task automatic do_reset();
        @(negedge clk);
        #2;
        aresetn = 1'b1;
        m_hold = 1'b0;
        s_x_tvalid = 1'b0;
        s_y_tvalid = 1'b0;
        #1;
        chk("rst_out_x", out_x, '0);
        chk("rst_out_y", out_y, '0);
        chk("rst_stall", 1'(stall), 1'b1);
        chk("rst_frame_end", 1'(frame_end), 1'b0);
        chk("rst_tlast_err", 1'(tlast_err), 1'b0);
        chk("rst_x_tready", 1'(s_x_tready), 1'b0);
        chk("rst_y_tready", 1'(s_y_tready), 1'b0);
        xq.delete();
        yq.delete();
        err_model = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("post_rst_x_tready", 1'(s_x_tready), 1'b1);
        chk("post_rst_y_tready", 1'(s_y_tready), 1'b1);
        chk("post_rst_stall", 1'(stall), 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Continuous streaming: stall low every cycle once the first pair lands.
        do_reset();
        fork
            send(1'b0, 0, 20, -1);
            send(1'b1, 0, 20, -1);
            begin
                @(negedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("latency_first_edge", 1'(stall), 1'b1);
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    chk("stream_stall", 1'(stall), 1'b0);
                end
            end
        join
        drain();

        // X fills while Y idles, then Y releases four pairs.
        do_reset();
        send(1'b0, 0, 4, -1);
        chk("x_full_tready", 1'(s_x_tready), 1'b0);
        chk("y_idle_tready", 1'(s_y_tready), 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("x_only_stall", 1'(stall), 1'b1);
        end
        send(1'b1, 0, 4, -1);
        drain();

        // Backpressure with two pairs queued.
        do_reset();
        fork send(1'b0, 0, 1, -1); send(1'b1, 0, 1, -1); join
        drain();
        m_hold = 1'b1;
        fork send(1'b0, 1, 2, -1); send(1'b1, 1, 2, -1); join
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_stall", 1'(stall), 1'b1);
            chk("hold_out_x", out_x, xdat(0));
            chk("hold_out_y", out_y, ydat(0));
        end
        m_hold = 1'b0;
        @(negedge clk); chk("release_beat1", 1'(stall), 1'b0);
        @(negedge clk); chk("release_beat2", 1'(stall), 1'b0);
        @(negedge clk); chk("release_done", 1'(stall), 1'b1);

        // Full clean frame, then a frame with an early Y tlast, then part of a third.
        do_reset();
        fe_cnt = 0;
        fork send(1'b0, 0, BEATS, -1); send(1'b1, 0, BEATS, -1); join
        drain();
        chk("frame1_fe_count", 32'(fe_cnt), 32'd1);
        chk("frame1_tlast_err", 1'(tlast_err), 1'b0);
        fork send(1'b0, BEATS, BEATS, -1); send(1'b1, BEATS, BEATS, 100); join
        drain();
        chk("frame2_fe_count", 32'(fe_cnt), 32'd2);
        chk("frame2_tlast_err", 1'(tlast_err), 1'b1);
        fork send(1'b0, 2 * BEATS, 50, -1); send(1'b1, 2 * BEATS, 50, -1); join
        drain();
        chk("frame3_tlast_err_sticky", 1'(tlast_err), 1'b1);

        // Reset with three pairs queued: nothing stale may appear afterwards.
        do_reset();
        fork send(1'b0, 0, 1, -1); send(1'b1, 0, 1, -1); join
        drain();
        m_hold = 1'b1;
        fork send(1'b0, 1, 3, -1); send(1'b1, 1, 3, -1); join
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_stale_stall", 1'(stall), 1'b1);
        end
        fork send(1'b0, 50, 1, -1); send(1'b1, 50, 1, -1); join
        drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
